// File: rtl/toy_vpack.sv
// Shared constants and types for the vector element and its systolic-array column.
package toy_vpack;
    localparam int V_REG_WIDTH = 32;
    localparam int SA_PE_NUM   = 4;
    localparam int SA_LANE_W   = 8;
    localparam int SA_LANE_NUM = V_REG_WIDTH / SA_LANE_W;
    // Four 16-bit lane products plus a bias byte fit in 18 signed bits.
    localparam int SA_DOT_W    = 2 * SA_LANE_W + 2;

    typedef logic signed [SA_DOT_W-1:0] sa_dot_t;
endpackage

// File: rtl/toy_sa_pe.sv
// One processing element: weight stage, activation/bias stage, lane MAC and accumulator with shift-in.
module toy_sa_pe
    import toy_vpack::*;
#(
    parameter int IDX    = 0,
    parameter int LANE_W = SA_LANE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic                   shift_en,
    input  logic [V_REG_WIDTH-1:0] w_in,
    input  logic [V_REG_WIDTH-1:0] x_in,
    input  logic [V_REG_WIDTH-1:0] y_in,
    input  logic                   v_in,
    input  logic [V_REG_WIDTH-1:0] acc_in,
    output logic [V_REG_WIDTH-1:0] w,
    output logic [V_REG_WIDTH-1:0] x,
    output logic [V_REG_WIDTH-1:0] y,
    output logic                   v,
    output logic [V_REG_WIDTH-1:0] acc
);
    localparam int LANES  = V_REG_WIDTH / LANE_W;
    localparam int PROD_W = 2 * LANE_W;

    sa_dot_t                  dot;
    logic signed [LANE_W-1:0] x_lane;
    logic signed [LANE_W-1:0] w_lane;
    logic signed [PROD_W-1:0] prod;
    logic [V_REG_WIDTH-1:0]   acc_base;
    logic [V_REG_WIDTH-1:0]   dot_add;

    // Bias travels with its beat in y, so each PE picks its own byte out of the word.
    always_comb begin
        x_lane = '0;
        w_lane = '0;
        prod   = '0;
        dot    = sa_dot_t'($signed(y[IDX*LANE_W +: LANE_W]));
        for (int l = 0; l < LANES; l++) begin
            x_lane = $signed(x[l*LANE_W +: LANE_W]);
            w_lane = $signed(w[l*LANE_W +: LANE_W]);
            prod   = x_lane * w_lane;
            dot    = dot + sa_dot_t'(prod);
        end
    end

    // Shift is applied before the add when both land in the same cycle.
    assign acc_base = shift_en ? acc_in : acc;
    assign dot_add  = v ? V_REG_WIDTH'(dot) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w   <= '0;
            x   <= '0;
            y   <= '0;
            v   <= 1'b0;
            acc <= '0;
        end else begin
            if (load_en) w <= w_in;
            v <= v_in;
            if (v_in) begin
                x <= x_in;
                y <= y_in;
            end
            acc <= acc_base + dot_add;
        end
    end
endmodule

// File: rtl/toy_sa_column.sv
// Systolic column of PE_NUM elements: weights and beats ripple down, results shift out of the last PE.
module toy_sa_column
    import toy_vpack::*;
#(
    parameter int PE_NUM = SA_PE_NUM,
    parameter int LANE_W = SA_LANE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [V_REG_WIDTH-1:0] sa_dout,
    input  logic                   sa_dout_en,
    input  logic [V_REG_WIDTH-1:0] sa_dout_y,
    input  logic                   sa_load_en,
    input  logic                   sa_shift_en,
    output logic [V_REG_WIDTH-1:0] sa_din,
    output logic                   sa_busy
);
    logic [V_REG_WIDTH-1:0] w_ch   [PE_NUM+1];
    logic [V_REG_WIDTH-1:0] x_ch   [PE_NUM+1];
    logic [V_REG_WIDTH-1:0] y_ch   [PE_NUM+1];
    logic [V_REG_WIDTH-1:0] acc_ch [PE_NUM+1];
    logic [PE_NUM:0]        v_ch;

    // A load in the same cycle as a beat wins; the beat is dropped.
    assign w_ch[0]   = sa_dout;
    assign x_ch[0]   = sa_dout;
    assign y_ch[0]   = sa_dout_y;
    assign v_ch[0]   = sa_dout_en & ~sa_load_en;
    assign acc_ch[0] = '0;

    for (genvar g = 0; g < PE_NUM; g++) begin : g_pe
        toy_sa_pe #(
            .IDX    (g),
            .LANE_W (LANE_W)
        ) u_pe (
            .clk      (clk),
            .rst      (rst),
            .load_en  (sa_load_en),
            .shift_en (sa_shift_en),
            .w_in     (w_ch[g]),
            .x_in     (x_ch[g]),
            .y_in     (y_ch[g]),
            .v_in     (v_ch[g]),
            .acc_in   (acc_ch[g]),
            .w        (w_ch[g+1]),
            .x        (x_ch[g+1]),
            .y        (y_ch[g+1]),
            .v        (v_ch[g+1]),
            .acc      (acc_ch[g+1])
        );
    end

    assign sa_din  = acc_ch[PE_NUM];
    assign sa_busy = |v_ch[PE_NUM:1];
endmodule

// File: tb/tb_toy_sa_column.sv
// Directed bench for toy_sa_column with hand-computed expected results.
module tb_toy_sa_column;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sa_dout = '0;
    logic         sa_dout_en = 1'b0;
    logic [W-1:0] sa_dout_y = '0;
    logic         sa_load_en = 1'b0;
    logic         sa_shift_en = 1'b0;
    logic [W-1:0] sa_din;
    logic         sa_busy;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    toy_sa_column #(.PE_NUM(4), .LANE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .sa_dout     (sa_dout),
        .sa_dout_en  (sa_dout_en),
        .sa_dout_y   (sa_dout_y),
        .sa_load_en  (sa_load_en),
        .sa_shift_en (sa_shift_en),
        .sa_din      (sa_din),
        .sa_busy     (sa_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] wv);
        sa_dout    = wv;
        sa_load_en = 1'b1;
        tick();
        sa_load_en = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] xv, input logic [W-1:0] yv);
        sa_dout    = xv;
        sa_dout_y  = yv;
        sa_dout_en = 1'b1;
        tick();
        sa_dout_en = 1'b0;
    endtask

    task automatic shift();
        sa_shift_en = 1'b1;
        tick();
        sa_shift_en = 1'b0;
    endtask

    // Drains the column, comparing each PE against exp_q (PE_NUM-1 first), then expects zeros.
    task automatic read_column(input string tag);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, sa_din, e);
            shift();
        end
        check({tag, "_empty"}, sa_din, '0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_din", sa_din, '0);
        check("rst_busy", {31'b0, sa_busy}, '0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_din", sa_din, '0);
        check("idle_busy", {31'b0, sa_busy}, '0);

        // Unit weights, one beat
        repeat (4) load(32'h0101_0101);
        beat(32'h0202_0202, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("busy_t%0d", k + 1), {31'b0, sa_busy}, 32'd1);
            tick();
        end
        check("busy_t5", {31'b0, sa_busy}, '0);
        check("din_t5", sa_din, 32'd8);
        repeat (4) exp_q.push_back(32'd8);
        read_column("unit");

        // Signed lanes: 4 * (127 * -1) = -508
        repeat (4) load(32'hFFFF_FFFF);
        beat(32'h7F7F_7F7F, 32'h0);
        repeat (4) tick();
        repeat (4) exp_q.push_back(32'hFFFF_FE04);
        read_column("signed");

        // Bias bytes per PE and output order
        repeat (4) load(32'h0);
        beat(32'h0, 32'h0403_0201);
        repeat (4) tick();
        exp_q.push_back(32'd4); exp_q.push_back(32'd3);
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        read_column("bias");
        beat(32'h0, 32'h0403_0201);
        beat(32'h0, 32'h0403_0201);
        repeat (4) tick();
        exp_q.push_back(32'd8); exp_q.push_back(32'd6);
        exp_q.push_back(32'd4); exp_q.push_back(32'd2);
        read_column("b2b");

        // Shift colliding with PE0 compute: acc0 = 0 + 5, acc1 = old acc0 = 7
        beat(32'h0, 32'h0000_0007);
        repeat (4) tick();
        sa_dout    = 32'h0;
        sa_dout_y  = 32'h0000_0005;
        sa_dout_en = 1'b1;
        tick();
        sa_dout_en  = 1'b0;
        sa_shift_en = 1'b1;
        tick();
        sa_shift_en = 1'b0;
        repeat (3) tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd7); exp_q.push_back(32'd5);
        read_column("collide");

        // Load and beat together: beat dropped, only w0 changes
        sa_dout    = 32'h0101_0101;
        sa_dout_y  = 32'h0403_0201;
        sa_load_en = 1'b1;
        sa_dout_en = 1'b1;
        tick();
        sa_load_en = 1'b0;
        sa_dout_en = 1'b0;
        check("ldmul_busy", {31'b0, sa_busy}, '0);
        repeat (4) tick();
        check("ldmul_din", sa_din, '0);
        beat(32'h0101_0101, 32'h0);
        repeat (4) tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd4);
        read_column("ldmul_w");

        // Wrap: 32767 * 65536 + 65535 = 0x7FFFFFFF, then +1
        repeat (4) load(32'h8080_8080);
        sa_dout    = 32'h8080_8080;
        sa_dout_y  = 32'h0;
        sa_dout_en = 1'b1;
        repeat (32767) tick();
        sa_dout_y = 32'hFFFF_FFFF;
        tick();
        sa_dout_en = 1'b0;
        repeat (4) tick();
        check("wrap_pre", sa_din, 32'h7FFF_FFFF);
        beat(32'h0, 32'h0101_0101);
        repeat (4) tick();
        repeat (4) exp_q.push_back(32'h8000_0000);
        read_column("wrap");

        // Asynchronous reset mid-cycle with beats in flight
        beat(32'h8080_8080, 32'h0);
        beat(32'h8080_8080, 32'h0);
        repeat (3) tick();
        check("pre_rst_din", sa_din, 32'h0001_0000);
        check("pre_rst_busy", {31'b0, sa_busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_din", sa_din, '0);
        check("arst_busy", {31'b0, sa_busy}, '0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("post_rst_din", sa_din, '0);
        check("post_rst_busy", {31'b0, sa_busy}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/toy_sa_column.md
# toy_sa_column

Responder end of the vector-element ↔ systolic-array link: one column of `PE_NUM` processing elements that receives weights (`sa_load_en`) and activation beats (`sa_dout_en`, `sa_dout`, `sa_dout_y`) from a vector element. It computes signed int8 dot-product accumulations and returns results on `sa_din`, one PE per `sa_shift_en` pulse. Activations ripple through the PEs systolically, one PE per cycle. `sa_busy` lets the element's sequencer wait for the column to drain.

## Interface
Parameters:
- `PE_NUM`, 4 — PEs in the column (≥2).
- `LANE_W`, 8 — lane width; `V_REG_WIDTH/LANE_W` lanes (4 at 32 bits).

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — reset, asynchronous, active-high.
- `sa_dout`  in  V_REG_WIDTH  — weight word on load; activation word on MUL beat.
- `sa_dout_en`  in  1  — MUL beat strobe.
- `sa_dout_y`  in  V_REG_WIDTH  — bias word; byte i goes to PE i (PE_NUM ≤ lane count).
- `sa_load_en`  in  1  — weight-load strobe.
- `sa_shift_en`  in  1  — result shift-out strobe.
- `sa_din`  out  V_REG_WIDTH  — registered value of `acc[PE_NUM-1]`.
- `sa_busy`  out  1  — OR of all beat-valid bits in the activation pipe.

## Operation
- Weight chain, on `sa_load_en`: `w[0]<=sa_dout` and `w[i]<=w[i-1]`. After PE_NUM loads W0..W3, PE0 holds W3 and PE3 holds W0.
- Activation pipe, on `sa_dout_en`: `x[0]<=sa_dout`, `v[0]<=1`, and PE i's bias byte is captured with the beat. Every cycle `x[i]<=x[i-1]` and `v[i]<=v[i-1]`; `v[0]<=0` when there is no beat.
- PE i, when `v[i]`:
  - `prod_i = Σ_lanes sext(x_lane)*sext(w_i_lane) + sext(bias_i)`
  - Products are 16 bits, the sum is 18 bits, sign-extended to V_REG_WIDTH.
  - `acc[i] <= acc[i] + prod_i`, wrapping mod 2^V_REG_WIDTH with no saturation.
- Shift, on `sa_shift_en`: `acc[i]<=acc[i-1]` and `acc[0]<=0`. Output order is PE_NUM-1 first, then down to PE0. After PE_NUM shifts the column reads all-zero.
- Simultaneous shift and valid product at PE i: `acc[i] <= acc[i-1] + prod_i` (shift first, then add). For PE0 this is `0 + prod_0`.
- Simultaneous `sa_load_en` and `sa_dout_en`: the load takes effect and the MUL beat is dropped (`v[0]<=0`).
- A weight load while `sa_busy=1`: in-flight beats use whatever `w[i]` holds in their compute cycle. Software must wait for `!sa_busy` before loading.
- No backpressure. Every strobe is accepted in the cycle it is high.

## Timing
- Reset: all `w`, `x`, `v`, `acc` and bias registers go to 0, so `sa_din=0` and `sa_busy=0`. Reset is effective immediately, including mid-beat; in-flight beats are discarded.
- Beat at cycle t:
  - `x[0]` and `v[0]` are valid at t+1.
  - PE i computes at t+1+i.
  - `acc[i]` shows the result from t+2+i.
  - `sa_din` (PE_NUM-1) reflects it at t+1+PE_NUM, which is t+5 for PE_NUM=4.
- `sa_busy` is high from t+1 through t+PE_NUM.
- A weight load at t is usable by a beat whose compute cycle is ≥ t+1.
- Shift at t: `sa_din` shows the next PE's accumulator at t+1. Back-to-back shifts are allowed every cycle.
- Back-to-back beats every cycle are supported, giving a throughput of one beat per cycle.

## Structure
- Add to `toy_vpack`: `SA_PE_NUM`, `SA_LANE_W`, `SA_LANE_NUM`.
- Add to `toy_vpack`: a `sa_dot_t` typedef for the 18-bit signed dot result.
- Sub-module `toy_sa_pe` (one per PE, generate loop). It holds `w`, `x`, `v`, bias and `acc`, plus the lane MAC and shift mux, and takes `acc_in` from its upstream PE.
- Top level instantiates the generate loop, forms `sa_busy`, and drives `sa_din`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `sa_din=0` and `sa_busy=0` immediately; both stay 0 after release with no strobes.
- Load 0x01010101 ×4, then one beat x=0x02020202, y=0 → `sa_busy` high for 4 cycles; `sa_din=8` at t+5. Four shifts read 8,8,8,8, then 0.
- Signed: weights 0xFFFFFFFF ×4, beat x=0x7F7F7F7F, y=0 → every acc = -508 = 0xFFFFFE04.
- Bias and order: weights 0, beat x=0, y=0x04030201 → shifts read 4,3,2,1. Two identical beats back-to-back read 8,6,4,2.
- Collision: `sa_shift_en` in the same cycle as PE0's compute (prod=5) with `acc[0]=7` beforehand → `acc[0]=5`, `acc[1]=7`. Load+MUL in the same cycle → weight chain shifts and no acc changes.
- Wrap: accumulate 0x7FFFFFFF plus a beat with prod=1 → `acc=0x80000000`, with no flag and no saturation.
